ls_arbiter: RTL and testbench

Local-store access controller that shares the single-port 128-bit local store between the SPU load/store pipe and the DMA engine. Pipe requests carry the 15-bit byte address produced by the load/store address ALU (lqa/lqd/stqa/stqd). The block arbitrates each cycle and drives the memory port. It tracks in-flight reads through a MEM_LAT-deep tag pipeline and returns read data to the owner. It sits between the odd-pipe LS stage and the local-store SRAM macro.

---
 rtl/ls_arbiter_if.sv | 56 +++++
 rtl/ls_arbiter.sv | 143 ++++++++++++++
 tb/tb_ls_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ls_arbiter_if.sv
// ls_arbiter_if: bundle of every request, return and memory-port signal of
// the local-store access controller.
//
// Handshake rules:
//   pipe: a pipe request is taken in a cycle where pipe_valid && pipe_ready.
//         pipe_ready may be high with no request present and never depends
//         on pipe_valid.
//   dma:  a DMA request is taken in a cycle where dma_gnt is high. dma_gnt
//         only asserts while dma_req is high.
//   wb_valid / dma_rvalid are one-cycle strobes that need no acknowledge.
//   ls_*: the SRAM port; ls_rdata carries the data of the read that was
//         issued MEM_LAT cycles earlier.
//
// Modports:
//   slave  - the arbiter side
//   master - the environment side (pipe, DMA engine and SRAM macro)
interface ls_arbiter_if;
    logic          pipe_valid;
    logic          pipe_ready;
    logic          pipe_is_store;
    logic [0:14]   pipe_addr;
    logic [0:127]  pipe_wdata;
    logic [0:6]    pipe_rt;
    logic          flush;
    logic          wb_valid;
    logic [0:6]    wb_rt;
    logic [0:127]  wb_data;
    logic          dma_req;
    logic          dma_we;
    logic [0:14]   dma_addr;
    logic [0:127]  dma_wdata;
    logic          dma_gnt;
    logic          dma_rvalid;
    logic [0:127]  dma_rdata;
    logic          ls_en;
    logic          ls_we;
    logic [0:10]   ls_addr;
    logic [0:127]  ls_wdata;
    logic [0:127]  ls_rdata;

    modport slave (
        input  pipe_valid, pipe_is_store, pipe_addr, pipe_wdata, pipe_rt, flush,
        input  dma_req, dma_we, dma_addr, dma_wdata, ls_rdata,
        output pipe_ready, wb_valid, wb_rt, wb_data,
        output dma_gnt, dma_rvalid, dma_rdata,
        output ls_en, ls_we, ls_addr, ls_wdata
    );

    modport master (
        output pipe_valid, pipe_is_store, pipe_addr, pipe_wdata, pipe_rt, flush,
        output dma_req, dma_we, dma_addr, dma_wdata, ls_rdata,
        input  pipe_ready, wb_valid, wb_rt, wb_data,
        input  dma_gnt, dma_rvalid, dma_rdata,
        input  ls_en, ls_we, ls_addr, ls_wdata
    );
endinterface

// File: rtl/ls_arbiter.sv
// ls_arbiter: shares the single-port 128-bit local store between the SPU
// load/store pipe and the DMA engine. One access per cycle; the pipe wins
// unless DMA has been denied STARVE_MAX cycles in a row. Reads are tracked
// through a MEM_LAT-deep tag pipeline so the returned quadword is steered
// to its owner.
//
// Parameters:
//   MEM_LAT    - cycles from an accepted read to valid ls_rdata (1..4)
//   STARVE_MAX - consecutive DMA denials before DMA is forced (1..255)
//
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   bus        - ls_arbiter_if.slave: pipe request/writeback, DMA
//                request/return and the SRAM port
//
// Optional build macro LS_ARB_STATS_EN adds the wrapping 32-bit counters
//   stat_pipe_acc, stat_dma_acc and stat_dma_forced.
module ls_arbiter #(
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 8
) (
    input  logic          clk,
    input  logic          rst,
    ls_arbiter_if.slave   bus
`ifdef LS_ARB_STATS_EN
    ,
    output logic [0:31]   stat_pipe_acc,
    output logic [0:31]   stat_dma_acc,
    output logic [0:31]   stat_dma_forced
`endif
);

    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);
    localparam int         TAIL       = MEM_LAT - 1;

    logic [7:0]         starve_cnt;
    logic               force_dma;
    logic               pipe_acc;
    logic               dma_acc;

    // Tag pipeline, stage 0 = newest, stage TAIL = the read whose data is on
    // ls_rdata this cycle.
    logic [MEM_LAT-1:0] tag_v;
    logic [MEM_LAT-1:0] tag_dma;
    logic [0:6]         tag_rt [MEM_LAT];
    logic               tail_v;

    // Sub-quadword address bits select nothing in a quadword-wide store.
    logic               unused_addr_bits;
    assign unused_addr_bits = ^{bus.pipe_addr[11:14], bus.dma_addr[11:14]};

    // ---------------- arbitration ----------------
    assign force_dma      = bus.dma_req && (starve_cnt == STARVE_LIM);
    assign bus.pipe_ready = !rst && !bus.flush && !force_dma;
    assign bus.dma_gnt    = !rst && bus.dma_req &&
                            (force_dma || !bus.pipe_valid || bus.flush);
    // pipe_acc needs !flush && !force_dma && pipe_valid, which makes dma_gnt
    // low, so the two grants are mutually exclusive by construction.
    assign pipe_acc       = bus.pipe_valid && bus.pipe_ready;
    assign dma_acc        = bus.dma_gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!bus.dma_req || bus.dma_gnt) begin
            starve_cnt <= '0;
        end else if (starve_cnt != STARVE_LIM) begin
            starve_cnt <= starve_cnt + 8'd1;
        end
    end

    // ---------------- memory port ----------------
    always_comb begin
        bus.ls_en    = pipe_acc || dma_acc;
        bus.ls_we    = 1'b0;
        bus.ls_addr  = '0;
        bus.ls_wdata = '0;
        if (pipe_acc) begin
            bus.ls_we    = bus.pipe_is_store;
            bus.ls_addr  = bus.pipe_addr[0:10];
            bus.ls_wdata = bus.pipe_wdata;
        end else if (dma_acc) begin
            bus.ls_we    = bus.dma_we;
            bus.ls_addr  = bus.dma_addr[0:10];
            bus.ls_wdata = bus.dma_wdata;
        end
    end

    // ---------------- tag pipeline ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_v   <= '0;
            tag_dma <= '0;
            for (int i = 0; i < MEM_LAT; i++) begin
                tag_rt[i] <= '0;
            end
        end else begin
            // A pipe request is never accepted under flush, so stage 0 needs
            // no flush qualification.
            tag_v[0]   <= (pipe_acc && !bus.pipe_is_store) ||
                          (dma_acc && !bus.dma_we);
            tag_dma[0] <= dma_acc;
            tag_rt[0]  <= pipe_acc ? bus.pipe_rt : '0;
            for (int i = 1; i < MEM_LAT; i++) begin
                // Flush kills in-flight pipe loads; DMA reads keep going.
                tag_v[i]   <= tag_v[i-1] && !(bus.flush && !tag_dma[i-1]);
                tag_dma[i] <= tag_dma[i-1];
                tag_rt[i]  <= tag_rt[i-1];
            end
        end
    end

    // Returns are gated by rst so reads in flight when reset hits never
    // surface, even in the reset cycle itself.
    assign tail_v         = tag_v[TAIL] && !rst;
    assign bus.wb_valid   = tail_v && !tag_dma[TAIL] && !bus.flush;
    assign bus.wb_rt      = bus.wb_valid ? tag_rt[TAIL] : '0;
    assign bus.wb_data    = bus.ls_rdata;
    assign bus.dma_rvalid = tail_v && tag_dma[TAIL];
    assign bus.dma_rdata  = bus.ls_rdata;

`ifdef LS_ARB_STATS_EN
    // ---------------- statistics ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_pipe_acc   <= '0;
            stat_dma_acc    <= '0;
            stat_dma_forced <= '0;
        end else begin
            if (pipe_acc) begin
                stat_pipe_acc <= stat_pipe_acc + 32'd1;
            end
            if (dma_acc) begin
                stat_dma_acc <= stat_dma_acc + 32'd1;
            end
            if (force_dma) begin
                stat_dma_forced <= stat_dma_forced + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ls_arbiter.sv
// tb_ls_arbiter: directed scenarios followed by randomized traffic for
// ls_arbiter, checked every cycle against a transaction-level model: a
// denial-streak counter decides the winner, a reference memory supplies
// read data, and a queue of pending returns (due cycle, owner, rt, data)
// predicts wb/dma returns.
module tb_ls_arbiter;
    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 8;

    logic clk = 1'b0;
    logic rst;

    ls_arbiter_if bus ();

`ifdef LS_ARB_STATS_EN
    logic [0:31] stat_pipe_acc;
    logic [0:31] stat_dma_acc;
    logic [0:31] stat_dma_forced;
`endif

    ls_arbiter #(
        .MEM_LAT    (MEM_LAT),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus)
`ifdef LS_ARB_STATS_EN
        ,
        .stat_pipe_acc   (stat_pipe_acc),
        .stat_dma_acc    (stat_dma_acc),
        .stat_dma_forced (stat_dma_forced)
`endif
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- SRAM macro model ----------------
    logic [127:0] sram    [2048];
    logic [127:0] rd_line [MEM_LAT];

    always @(posedge clk) begin
        if (bus.ls_en && bus.ls_we) sram[bus.ls_addr] <= bus.ls_wdata;
        rd_line[0] <= (bus.ls_en && !bus.ls_we) ? sram[bus.ls_addr] : 128'h0;
        for (int i = 1; i < MEM_LAT; i++) rd_line[i] <= rd_line[i-1];
    end
    assign bus.ls_rdata = rd_line[MEM_LAT-1];

    // ---------------- reference model state ----------------
    typedef struct {
        int           due;
        bit           is_dma;
        logic [6:0]   rt;
        logic [127:0] data;
    } pend_t;

    logic [127:0] ref_mem [2048];
    pend_t        pend_q [$];
    int           streak;
    int           m_pipe_acc, m_dma_acc, m_forced;
    int           cyc;
    int           n_checks, n_pass;
    int           obs_wb, obs_dv, obs_gnt;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Checks every output for the current cycle, then advances the model.
    task automatic eval();
        logic         force_d, e_ready, e_gnt, e_pacc, e_en, e_we, e_wb, e_dv;
        logic [10:0]  e_addr;
        logic [127:0] e_wdata, e_wbd, e_dd;
        logic [6:0]   e_rt;
        pend_t        ent;
        #1;
        obs_wb  += int'(bus.wb_valid);
        obs_dv  += int'(bus.dma_rvalid);
        obs_gnt += int'(bus.dma_gnt);
        if (rst) begin
            chk("rst_pipe_ready", bus.pipe_ready, 0);
            chk("rst_dma_gnt",    bus.dma_gnt, 0);
            chk("rst_ls_en",      bus.ls_en, 0);
            chk("rst_ls_we",      bus.ls_we, 0);
            chk("rst_ls_addr",    bus.ls_addr, 0);
            chk("rst_ls_wdata",   bus.ls_wdata, 0);
            chk("rst_wb_valid",   bus.wb_valid, 0);
            chk("rst_wb_rt",      bus.wb_rt, 0);
            chk("rst_dma_rvalid", bus.dma_rvalid, 0);
            pend_q.delete();
            streak     = 0;
            m_pipe_acc = 0;
            m_dma_acc  = 0;
            m_forced   = 0;
        end else begin
`ifdef LS_ARB_STATS_EN
            chk("stat_pipe_acc",   stat_pipe_acc,   128'(32'(m_pipe_acc)));
            chk("stat_dma_acc",    stat_dma_acc,    128'(32'(m_dma_acc)));
            chk("stat_dma_forced", stat_dma_forced, 128'(32'(m_forced)));
`endif
            force_d = bus.dma_req && (streak == STARVE_MAX);
            e_ready = !bus.flush && !force_d;
            e_gnt   = bus.dma_req && (force_d || !bus.pipe_valid || bus.flush);
            e_pacc  = bus.pipe_valid && e_ready;

            if (bus.flush) begin
                for (int i = pend_q.size() - 1; i >= 0; i--)
                    if (!pend_q[i].is_dma) pend_q.delete(i);
            end

            e_wb = 1'b0; e_dv = 1'b0; e_rt = '0; e_wbd = '0; e_dd = '0;
            if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
                ent = pend_q.pop_front();
                if (ent.is_dma) begin
                    e_dv = 1'b1; e_dd = ent.data;
                end else begin
                    e_wb = 1'b1; e_rt = ent.rt; e_wbd = ent.data;
                end
            end

            e_en = e_pacc || e_gnt; e_we = 1'b0; e_addr = '0; e_wdata = '0;
            if (e_pacc) begin
                e_we = bus.pipe_is_store; e_addr = 11'(bus.pipe_addr >> 4); e_wdata = bus.pipe_wdata;
            end else if (e_gnt) begin
                e_we = bus.dma_we; e_addr = 11'(bus.dma_addr >> 4); e_wdata = bus.dma_wdata;
            end

            chk("pipe_ready", bus.pipe_ready, e_ready);
            chk("dma_gnt",    bus.dma_gnt, e_gnt);
            chk("ls_en",      bus.ls_en, e_en);
            chk("ls_we",      bus.ls_we, e_we);
            if (e_en) chk("ls_addr", bus.ls_addr, e_addr);
            if (e_en && e_we) chk("ls_wdata", bus.ls_wdata, e_wdata);
            chk("wb_valid",   bus.wb_valid, e_wb);
            chk("dma_rvalid", bus.dma_rvalid, e_dv);
            if (e_wb) begin
                chk("wb_rt",   bus.wb_rt, e_rt);
                chk("wb_data", bus.wb_data, e_wbd);
            end
            if (e_dv) chk("dma_rdata", bus.dma_rdata, e_dd);

            if (e_en && !e_we) begin
                ent.due    = cyc + MEM_LAT;
                ent.is_dma = !e_pacc;
                ent.rt     = e_pacc ? 7'(bus.pipe_rt) : 7'd0;
                ent.data   = ref_mem[e_addr];
                pend_q.push_back(ent);
            end
            if (e_en && e_we) ref_mem[e_addr] = e_wdata;

            if (bus.dma_req && !e_gnt) begin
                if (streak < STARVE_MAX) streak++;
            end else begin
                streak = 0;
            end
            if (e_pacc) m_pipe_acc++;
            if (e_gnt)  m_dma_acc++;
            if (force_d) m_forced++;
        end
        cyc++;
    endtask

    task automatic adv();
        @(negedge clk);
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle();
        bus.pipe_valid = 1'b0; bus.pipe_is_store = 1'b0; bus.pipe_addr = '0;
        bus.pipe_wdata = '0;   bus.pipe_rt = '0;         bus.flush = 1'b0;
        bus.dma_req = 1'b0;    bus.dma_we = 1'b0;        bus.dma_addr = '0;
        bus.dma_wdata = '0;
    endtask

    task automatic set_pipe(input logic st, input logic [14:0] a, input logic [127:0] d, input logic [6:0] rt);
        bus.pipe_valid = 1'b1; bus.pipe_is_store = st; bus.pipe_addr = a;
        bus.pipe_wdata = d;    bus.pipe_rt = rt;
    endtask

    task automatic set_dma(input logic we, input logic [14:0] a, input logic [127:0] d);
        bus.dma_req = 1'b1; bus.dma_we = we; bus.dma_addr = a; bus.dma_wdata = d;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [14:0] rnd_addr();
        // Half of the addresses land in a small window to force reuse.
        if ($urandom_range(0, 1) == 1) return 15'($urandom_range(0, 7) * 16 + $urandom_range(0, 15));
        return 15'($urandom);
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic [127:0] q;
        logic [14:0]  da;
        logic [14:0]  pa;
        n_checks = 0; n_pass = 0; cyc = 0; streak = 0;
        m_pipe_acc = 0; m_dma_acc = 0; m_forced = 0;
        obs_wb = 0; obs_dv = 0; obs_gnt = 0;
        for (int i = 0; i < 2048; i++) begin
            q = rnd128();
            sram[i]    <= q;
            ref_mem[i] =  q;
        end

        // Reset
        rst = 1'b1; idle();
        eval(); adv();
        eval(); adv();
        rst = 1'b0;

        // Pipe load from 0x0130, rt 5
        set_pipe(1'b0, 15'h0130, '0, 7'd5);
        eval();
        chk("t1_ls_en", bus.ls_en, 1);
        chk("t1_ls_we", bus.ls_we, 0);
        chk("t1_ls_addr", bus.ls_addr, 11'h013);
        adv();
        idle(); eval(); adv();
        eval();
        chk("t1_wb_valid", bus.wb_valid, 1);
        chk("t1_wb_rt", bus.wb_rt, 5);
        chk("t1_wb_data", bus.wb_data, ref_mem[11'h013]);
        adv();

        // Store then load 0x7FF0
        set_pipe(1'b1, 15'h7FF0, {16{8'hA5}}, 7'd0); eval(); adv();
        set_pipe(1'b0, 15'h7FF0, '0, 7'd9); eval(); adv();
        idle(); eval();
        chk("t2_no_store_wb", bus.wb_valid, 0);
        adv();
        eval();
        chk("t2_wb_valid", bus.wb_valid, 1);
        chk("t2_wb_rt", bus.wb_rt, 9);
        chk("t2_wb_data", bus.wb_data, {16{8'hA5}});
        adv();

        // Starvation: continuous pipe loads against a DMA read, after reset
        rst = 1'b1; eval(); adv(); rst = 1'b0;
        for (int i = 0; i < 18; i++) begin
            pa = rnd_addr(); da = rnd_addr();
            set_pipe(1'b0, pa, '0, 7'($urandom));
            set_dma(1'b0, da, '0);
            eval();
            chk("t3_dma_gnt", bus.dma_gnt, (i % (STARVE_MAX + 1)) == STARVE_MAX);
            chk("t3_pipe_ready", bus.pipe_ready, (i % (STARVE_MAX + 1)) != STARVE_MAX);
            chk("t3_ls_addr", bus.ls_addr,
                ((i % (STARVE_MAX + 1)) == STARVE_MAX) ? 11'(da >> 4) : 11'(pa >> 4));
            adv();
        end
        idle(); eval();
`ifdef LS_ARB_STATS_EN
        chk("t3_stat_forced", stat_dma_forced, 2);
        chk("t3_stat_dma", stat_dma_acc, 2);
        chk("t3_stat_pipe", stat_pipe_acc, 16);
`endif
        adv();
        for (int i = 0; i < 3; i++) begin eval(); adv(); end

        // Flush kills loads rt1/rt2, load rt3 under flush is refused
        obs_wb = 0;
        set_pipe(1'b0, rnd_addr(), '0, 7'd1); eval(); adv();
        set_pipe(1'b0, rnd_addr(), '0, 7'd2); eval(); adv();
        set_pipe(1'b0, rnd_addr(), '0, 7'd3); bus.flush = 1'b1; eval();
        chk("t4_ready_flush", bus.pipe_ready, 0);
        adv();
        idle();
        for (int i = 0; i < 3; i++) begin eval(); adv(); end
        chk("t4_no_wb", obs_wb, 0);

        // Flush with a DMA read in flight
        obs_wb = 0;
        set_pipe(1'b0, rnd_addr(), '0, 7'd1); eval(); adv();
        idle(); set_dma(1'b0, 15'h2340, '0); eval();
        chk("t4b_dma_gnt", bus.dma_gnt, 1);
        adv();
        idle(); set_pipe(1'b0, rnd_addr(), '0, 7'd3); bus.flush = 1'b1; eval(); adv();
        idle(); eval();
        chk("t4b_dma_rvalid", bus.dma_rvalid, 1);
        chk("t4b_dma_rdata", bus.dma_rdata, ref_mem[11'h234]);
        adv();
        for (int i = 0; i < 2; i++) begin eval(); adv(); end
        chk("t4b_no_wb", obs_wb, 0);

        // Reset with two reads in flight
        set_pipe(1'b0, rnd_addr(), '0, 7'd7); eval(); adv();
        idle(); set_dma(1'b0, rnd_addr(), '0); eval(); adv();
        obs_wb = 0; obs_dv = 0;
        idle(); rst = 1'b1; eval(); adv();
        rst = 1'b0; set_pipe(1'b0, rnd_addr(), '0, 7'd11); eval();
        chk("t5_ready_after_rst", bus.pipe_ready, 1);
        adv();
        idle(); eval(); adv();
        chk("t5_no_wb", obs_wb, 0);
        chk("t5_no_dv", obs_dv, 0);
        for (int i = 0; i < 2; i++) begin eval(); adv(); end

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            idle();
            if ($urandom_range(0, 9) < 7)
                set_pipe($urandom_range(0, 2) == 0, rnd_addr(), rnd128(), 7'($urandom));
            bus.flush = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 1) == 1)
                set_dma($urandom_range(0, 2) == 0, rnd_addr(), rnd128());
            eval(); adv();
        end
        rst = 1'b0; idle();
        for (int i = 0; i < MEM_LAT + 2; i++) begin eval(); adv(); end
        chk("drain_pending", pend_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
